// File: rtl/count_uart_tx.sv
// rtl/count_uart_tx.sv - UART 8N1 transmitter for counter bytes, raw or ASCII-hex with CR
module count_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] data_in,
  input  logic       data_valid,
  input  logic       hex_mode,
  output logic       data_ready,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    char_idx;
  logic [7:0]    shreg;
  logic [3:0]    lo_q;
  logic          mode_q;
  logic          bit_end;
  logic          last_char;

  // Upper-case ASCII for one hex digit
  function automatic logic [7:0] hex_char(input logic [3:0] n);
    if (n < 4'd10) hex_char = 8'h30 + {4'h0, n};
    else           hex_char = 8'h37 + {4'h0, n};
  endfunction

  assign bit_end   = (cnt == CNT_MAX);
  // Raw mode sends a single character; hex mode ends after the CR (index 2)
  assign last_char = mode_q ? (char_idx == 2'd2) : 1'b1;

  // Sequence FSM: accept, then start/data/stop bits per character, registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      char_idx   <= '0;
      shreg      <= '0;
      lo_q       <= '0;
      mode_q     <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      data_ready <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          busy     <= 1'b0;
          cnt      <= '0;
          bit_idx  <= '0;
          char_idx <= '0;
          if (data_valid && data_ready) begin
            state      <= START;
            tx         <= 1'b0;
            busy       <= 1'b1;
            data_ready <= 1'b0;
            lo_q       <= data_in[3:0];
            mode_q     <= hex_mode;
            shreg      <= hex_mode ? hex_char(data_in[7:4]) : data_in;
          end else begin
            data_ready <= ena;
          end
        end
        START: begin
          if (bit_end) begin
            cnt   <= '0;
            state <= DATA;
            tx    <= shreg[0];
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              tx      <= 1'b1;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[1];
              shreg   <= {1'b0, shreg[7:1]};
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            cnt <= '0;
            if (last_char) begin
              state      <= IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              data_ready <= ena;
            end else begin
              state    <= START;
              tx       <= 1'b0;
              char_idx <= char_idx + 1'b1;
              shreg    <= (char_idx == 2'd0) ? hex_char(lo_q) : 8'h0D;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_tx.sv
// tb/tb_count_uart_tx.sv - directed self-checking bench for count_uart_tx
module tb_count_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] data_in;
  logic       data_valid;
  logic       hex_mode;
  logic       data_ready;
  logic       tx;
  logic       busy;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  count_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .data_in    (data_in),
    .data_valid (data_valid),
    .hex_mode   (hex_mode),
    .data_ready (data_ready),
    .tx         (tx),
    .busy       (busy),
    .done       (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Checks one full character frame starting the cycle after it begins
  task automatic expect_char(input logic [7:0] c);
    logic e;
    for (int b = 0; b < 10; b++) begin
      if (b == 0)      e = 1'b0;
      else if (b == 9) e = 1'b1;
      else             e = c[b-1];
      for (int k = 0; k < CPB; k++) begin
        @(negedge clk);
        chk($sformatf("tx c=%02h b=%0d k=%0d", c, b, k), tx, e);
        chk($sformatf("busy c=%02h b=%0d", c, b), busy, 1'b1);
        chk($sformatf("done c=%02h b=%0d", c, b), done, 1'b0);
        chk($sformatf("ready c=%02h b=%0d", c, b), data_ready, 1'b0);
      end
    end
  endtask

  task automatic check_done(input logic exp_ready);
    @(negedge clk);
    chk("done_pulse", done, 1'b1);
    chk("done_busy", busy, 1'b0);
    chk("done_tx", tx, 1'b1);
    chk("done_ready", data_ready, exp_ready);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n      = 1'b0;
    ena        = 1'b0;
    data_in    = 8'h00;
    data_valid = 1'b0;
    hex_mode   = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", data_ready, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    rst_n = 1'b1;
    ena   = 1'b1;
    @(negedge clk);
    chk("first_ready", data_ready, 1'b1);

    // Raw 0xA5
    data_in    = 8'hA5;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    expect_char(8'hA5);
    check_done(1'b1);
    @(negedge clk);
    chk("after_done_a5", done, 1'b0);

    // Hex 0x3C -> '3' 'C' CR
    data_in    = 8'h3C;
    hex_mode   = 1'b1;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    hex_mode = 1'b0;
    expect_char(8'h33);
    expect_char(8'h43);
    expect_char(8'h0D);
    check_done(1'b1);

    // ena low blocks accepts
    ena        = 1'b0;
    data_valid = 1'b0;
    @(negedge clk);
    chk("ena0_ready", data_ready, 1'b0);
    chk("ena0_done", done, 1'b0);
    data_in    = 8'h96;
    data_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("ena0_hold_ready %0d", i), data_ready, 1'b0);
      chk($sformatf("ena0_hold_tx %0d", i), tx, 1'b1);
      chk($sformatf("ena0_hold_busy %0d", i), busy, 1'b0);
    end
    ena = 1'b1;
    @(negedge clk);
    chk("ena1_ready", data_ready, 1'b1);
    chk("ena1_busy", busy, 1'b0);
    @(posedge clk);
    #1 data_valid = 1'b0;
    expect_char(8'h96);
    check_done(1'b1);
    @(negedge clk);
    chk("idle_before_b2b", done, 1'b0);

    // Back-to-back raw 0x00 then 0xFF, data_valid held
    data_in    = 8'h00;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_in = 8'hFF;
    expect_char(8'h00);
    check_done(1'b1);
    @(posedge clk);
    #1 data_valid = 1'b0;
    expect_char(8'hFF);
    check_done(1'b1);

    // data_in changes while busy
    data_in    = 8'h34;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_in = 8'h12;
    hex_mode   = 1'b1;
    data_valid = 1'b0;
    expect_char(8'h34);
    check_done(1'b1);
    hex_mode = 1'b0;

    // Reset mid-DATA of 0x55
    data_in    = 8'h55;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid_tx_bit1", tx, 1'b0);
    chk("mid_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_tx", tx, 1'b1);
    chk("async_rst_busy", busy, 1'b0);
    chk("async_rst_ready", data_ready, 1'b0);
    chk("async_rst_done", done, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", data_ready, 1'b1);
    chk("post_rst_tx", tx, 1'b1);
    chk("post_rst_busy", busy, 1'b0);
    data_in    = 8'h55;
    data_valid = 1'b1;
    @(posedge clk);
    #1 data_valid = 1'b0;
    expect_char(8'h55);
    check_done(1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/count_uart_tx.md
COUNT_UART_TX -- requirements
Module: count_uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 16, clock cycles per UART bit; legal range 2..65535.
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port ena  input  1  block enable; gates new transfers only.
REQ-005 SHALL have port data_in  input  8  byte from the upstream counter stage.
REQ-006 SHALL have port data_valid  input  1  data_in is valid this cycle.
REQ-007 SHALL have port hex_mode  input  1  0 = send raw byte; 1 = send two ASCII hex chars plus CR.
REQ-008 SHALL have port data_ready  output  1  registered; block can accept a byte.
REQ-009 SHALL have port tx  output  1  registered UART 8N1 serial line, idle high.
REQ-010 SHALL have port busy  output  1  registered; a transmission sequence is in progress.
REQ-011 SHALL have port done  output  1  registered; one-cycle pulse after the last stop bit of a sequence.

Function
REQ-012 SHALL accept a byte on any rising edge where data_valid=1 and data_ready=1, capturing data_in and hex_mode on that edge.
REQ-013 SHALL clear data_ready on the accepting edge and hold it at 0 until the sequence completes.
REQ-014 SHALL set data_ready only on an edge where the FSM is IDLE and ena=1; ena=0 in IDLE clears it on the next edge.
REQ-015 SHALL use FSM states IDLE, START, DATA, STOP: IDLE->START on accept; START->DATA after CLKS_PER_BIT cycles; DATA->STOP after 8 bit periods; STOP->START if characters remain, else STOP->IDLE.
REQ-016 SHALL drive tx=0 for START, data bits LSB first in DATA, and tx=1 for STOP, each lasting exactly CLKS_PER_BIT cycles.
REQ-017 SHALL begin the start bit (tx=0) in the cycle immediately after the accepting edge.
REQ-018 SHALL, in raw mode, send one character equal to the captured byte: 10*CLKS_PER_BIT cycles in total.
REQ-019 SHALL, in hex mode, send three characters back to back: upper-case ASCII of the high nibble, then of the low nibble (0-9 -> 0x30-0x39, A-F -> 0x41-0x46), then 0x0D.
REQ-020 SHALL insert no idle cycles between characters within one sequence.
REQ-021 SHALL drive busy=1 from the cycle after the accept through the last stop-bit cycle; busy=0 otherwise.
REQ-022 SHALL pulse done=1 for exactly one cycle, the cycle after the last stop-bit cycle, with tx=1 and busy=0 in that cycle.
REQ-023 SHALL set data_ready on the same edge that raises done if ena=1, giving back-to-back accepts with zero idle bit periods.
REQ-024 SHALL ignore data_valid, data_in, hex_mode and ena while busy=1; a sequence in progress always completes.
REQ-025 SHALL size the bit-period counter as clog2(CLKS_PER_BIT) bits, wrapping to 0 at CLKS_PER_BIT-1; no off-by-one across bit boundaries.

Reset
REQ-026 SHALL, while rst_n=0 and regardless of clk, force tx=1, data_ready=0, busy=0, done=0 and FSM=IDLE, and clear all counters.
REQ-027 SHALL abort any frame asserted mid-transmission when reset is asserted, with tx returning high immediately and no partial character resumed.
REQ-028 SHALL make the first possible data_ready=1 occur on the first rising edge after rst_n deasserts, with ena=1.

Verification (CLKS_PER_BIT=4)
REQ-029 SHALL cover: raw mode, data_in=0xA5 accepted -> tx = 0,1,0,1,0,0,1,0,1,1 for 4 cycles each (40 cycles); done pulses at cycle 41; busy high for cycles 1-40.
REQ-030 SHALL cover: hex mode, data_in=0x3C -> characters 0x33, 0x43, 0x0D back to back (120 cycles); exactly one done pulse.
REQ-031 SHALL cover: ena=0 with data_valid=1 held for 20 cycles -> data_ready=0, tx=1, and no accept; after ena=1, data_ready rises on the next edge and the byte is accepted.
REQ-032 SHALL cover: data_valid held high across two raw bytes 0x00 then 0xFF -> second start bit begins in the cycle after done; no idle gap.
REQ-033 SHALL cover: rst_n pulsed low mid-DATA of 0x55 -> tx=1 and busy=0 asynchronously; next accept sends a complete, correct frame.
REQ-034 SHALL cover: data_in changed to 0x12 while busy with 0x34 -> transmitted bits match 0x34 only.
